urv_mul_sequencer: RTL and testbench

Multi-cycle 32x32 multiply sequencer for the uRV execute stage. It drives a single registered 18x18 signed multiplier (`urv_mult18x18`) through four partial products and accumulates them into an exact 64-bit product. It returns the low word for MUL and the high word for MULH/MULHSU/MULHU. Start/done handshake; intended for area-constrained builds that cannot afford three parallel multipliers.

---
 rtl/urv_mul_pkg.sv | 30 +++
 rtl/urv_mult18x18.sv | 20 ++
 rtl/urv_mul_sequencer.sv | 118 +++++++++++
 tb/tb_urv_mul_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/urv_mul_pkg.sv
// Shared types and funct codes for the uRV multi-cycle multiplier.
// Funct codes follow RISC-V funct3[1:0] for the M-extension multiplies.
package urv_mul_pkg;

   localparam logic [1:0] FUN_MUL    = 2'd0;
   localparam logic [1:0] FUN_MULH   = 2'd1;
   localparam logic [1:0] FUN_MULHSU = 2'd2;
   localparam logic [1:0] FUN_MULHU  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } mul_state_e;

   // Partial product of step k, sign-extended and placed at its weight.
   function automatic logic [65:0] place_pp(input logic [35:0] p,
                                            input logic [1:0]  step);
      logic [65:0] ext;
      ext = {{30{p[35]}}, p};
      unique case (step)
         2'd0:    place_pp = ext;
         2'd1,
         2'd2:    place_pp = ext << 16;
         default: place_pp = ext << 32;
      endcase
   endfunction

endpackage

// File: rtl/urv_mult18x18.sv
// Registered 18x18 signed multiplier, generic implementation.
// The product register only updates when stall_i is low.
module urv_mult18x18 (
   input  logic        clk_i,
   input  logic        stall_i,
   input  logic [17:0] a_i,
   input  logic [17:0] b_i,
   output logic [35:0] q_o
);

   logic [35:0] q_q;

   always_ff @(posedge clk_i) begin
      if (!stall_i)
         q_q <= $signed(a_i) * $signed(b_i);
   end

   assign q_o = q_q;

endmodule

// File: rtl/urv_mul_sequencer.sv
// 32x32 multiply built from four 18x18 partial products on one
// registered multiplier; returns low word (MUL) or high word.
module urv_mul_sequencer
   import urv_mul_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [1:0]  fun_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic        kill_i,
   output logic        ready_o,
   output logic        done_o,
   output logic [31:0] result_o
);

   mul_state_e  state_q, state_d;
   logic [1:0]  step_q, step_d;
   logic [1:0]  fun_q, fun_d;
   logic [32:0] a_q, a_d;
   logic [32:0] b_q, b_d;
   logic [65:0] acc_q, acc_d;
   logic [31:0] result_q, result_d;
   logic        done_q, done_d;

   logic        accept;
   logic        stall;
   logic [17:0] mul_a;
   logic [17:0] mul_b;
   logic [35:0] prod;

   assign ready_o  = (state_q == S_IDLE) | (state_q == S_DONE);
   assign accept   = start_i & ready_o & ~kill_i;
   assign done_o   = done_q;
   assign result_o = result_q;

   // step[1] selects the high half of a, step[0] the high half of b
   assign mul_a = step_q[1] ? {a_q[32], a_q[32:16]} : {2'b00, a_q[15:0]};
   assign mul_b = step_q[0] ? {b_q[32], b_q[32:16]} : {2'b00, b_q[15:0]};
   assign stall = (state_q != S_ISSUE);

   urv_mult18x18 u_mult (
      .clk_i   (clk_i),
      .stall_i (stall),
      .a_i     (mul_a),
      .b_i     (mul_b),
      .q_o     (prod)
   );

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      fun_d    = fun_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      done_d   = 1'b0;

      unique case (state_q)
         S_ISSUE: begin
            if (step_q != 2'd0)
               acc_d = acc_q + place_pp(prod, 2'(step_q - 2'd1));
            step_d = 2'(step_q + 2'd1);
            if (step_q == 2'd3)
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            acc_d    = acc_q + place_pp(prod, 2'd3);
            result_d = (fun_q == FUN_MUL) ? acc_d[31:0] : acc_d[63:32];
            done_d   = 1'b1;
            state_d  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: ;
      endcase

      if (kill_i && (state_q == S_ISSUE || state_q == S_DRAIN)) begin
         state_d  = S_IDLE;
         done_d   = 1'b0;
         result_d = result_q;
      end

      if (accept) begin
         fun_d   = fun_i;
         a_d     = {rs1_i[31] & (fun_i == FUN_MULH || fun_i == FUN_MULHSU),
                    rs1_i};
         b_d     = {rs2_i[31] & (fun_i == FUN_MULH), rs2_i};
         acc_d   = '0;
         step_d  = 2'd0;
         state_d = S_ISSUE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         step_q   <= 2'd0;
         fun_q    <= FUN_MUL;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         fun_q    <= fun_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_urv_mul_sequencer.sv
// Directed and randomized checks of urv_mul_sequencer against a
// 66-bit arithmetic reference of the RISC-V multiply semantics.
module tb_urv_mul_sequencer;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [1:0]  fun_i;
   logic [31:0] rs1_i;
   logic [31:0] rs2_i;
   logic        kill_i;
   logic        ready_o;
   logic        done_o;
   logic [31:0] result_o;

   int compared   = 0;
   int mismatched = 0;

   urv_mul_sequencer dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .start_i  (start_i),
      .fun_i    (fun_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .kill_i   (kill_i),
      .ready_o  (ready_o),
      .done_o   (done_o),
      .result_o (result_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_mul(input logic [1:0]  f,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [65:0] sa, sb, p;
      sa = (f == 2'd1 || f == 2'd2) ? {{34{a[31]}}, a} : {34'b0, a};
      sb = (f == 2'd1) ? {{34{b[31]}}, b} : {34'b0, b};
      p  = sa * sb;
      return (f == 2'd0) ? p[31:0] : p[63:32];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Call at a negedge with ready_o high; returns in the done cycle.
   task automatic run_op(input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] res,
                         output int lat);
      start_i = 1'b1;
      fun_i   = f;
      rs1_i   = a;
      rs2_i   = b;
      lat     = 0;
      do begin
         @(negedge clk);
         lat++;
         start_i = 1'b0;
         fun_i   = 2'($urandom);
         rs1_i   = $urandom;
         rs2_i   = $urandom;
      end while (!done_o && lat < 20);
      res = result_o;
   endtask

   task automatic op_check(input string tag, input logic [1:0] f,
                           input logic [31:0] a, input logic [31:0] b);
      logic [31:0] res;
      int          lat;
      run_op(f, a, b, res, lat);
      chk({tag, " latency"}, 32'(lat), 32'd6);
      chk({tag, " result"}, res, ref_mul(f, a, b));
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done_o) n++;
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] corners [5];
      corners = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
      if ($urandom_range(3) == 0)
         return corners[$urandom_range(4)];
      return $urandom;
   endfunction

   initial begin
      logic [31:0] res;
      int          lat;
      int          n;

      rst_i   = 1'b1;
      start_i = 1'b0;
      kill_i  = 1'b0;
      fun_i   = 2'd0;
      rs1_i   = '0;
      rs2_i   = '0;
      repeat (2) @(negedge clk);
      chk("reset ready", 32'(ready_o), 32'd1);
      chk("reset done", 32'(done_o), 32'd0);
      chk("reset result", result_o, 32'd0);
      rst_i = 1'b0;
      @(negedge clk);

      run_op(2'd0, 32'h12345678, 32'h9, res, lat);
      chk("mul latency", 32'(lat), 32'd6);
      chk("mul result", res, 32'hA3D70A38);
      op_check("mulhu ff", 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("mulhu ff const", result_o, 32'hFFFFFFFE);
      op_check("mulh ff", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("mulh ff const", result_o, 32'h0);
      op_check("mulhsu ff", 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("mulhsu ff const", result_o, 32'hFFFFFFFF);

      op_check("mulh 8000", 2'd1, 32'h80000000, 32'h80000000);
      chk("mulh 8000 const", result_o, 32'h40000000);
      chk("ready in done", 32'(ready_o), 32'd1);
      run_op(2'd0, 32'd3, 32'd5, res, lat);
      chk("b2b latency", 32'(lat), 32'd6);
      chk("b2b result", res, 32'hF);

      @(negedge clk);
      start_i = 1'b1;
      fun_i   = 2'd3;
      rs1_i   = 32'hFFFFFFFF;
      rs2_i   = 32'hFFFFFFFF;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      chk("kill ready", 32'(ready_o), 32'd1);
      chk("kill done now", 32'(done_o), 32'd0);
      count_done(8, n);
      chk("kill no done", 32'(n), 32'd0);
      chk("kill result hold", result_o, 32'hF);

      start_i = 1'b1;
      fun_i   = 2'd0;
      rs1_i   = 32'd7;
      rs2_i   = 32'd6;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (done_o) begin
            n++;
            start_i = 1'b0;
         end
      end
      start_i = 1'b0;
      chk("held start count", 32'(n), 32'd1);
      chk("held start result", result_o, 32'd42);

      run_op(2'd0, 32'd11, 32'd13, res, lat);
      chk("pre kill-done result", res, 32'd143);
      kill_i  = 1'b1;
      start_i = 1'b1;
      #1;
      chk("kill in done keeps done", 32'(done_o), 32'd1);
      @(negedge clk);
      kill_i  = 1'b0;
      start_i = 1'b0;
      count_done(8, n);
      chk("kill in done no accept", 32'(n), 32'd0);

      start_i = 1'b1;
      kill_i  = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      kill_i  = 1'b0;
      chk("kill idle ready", 32'(ready_o), 32'd1);
      count_done(8, n);
      chk("kill idle no done", 32'(n), 32'd0);

      start_i = 1'b1;
      fun_i   = 2'd0;
      rs1_i   = 32'd100;
      rs2_i   = 32'd100;
      @(negedge clk);
      start_i = 1'b0;
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      chk("midrst ready", 32'(ready_o), 32'd1);
      chk("midrst done", 32'(done_o), 32'd0);
      chk("midrst result", result_o, 32'd0);
      rst_i = 1'b0;
      @(negedge clk);
      op_check("post rst mulhu", 2'd3, 32'h00010000, 32'h00010000);
      chk("post rst const", result_o, 32'h1);

      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(7) == 0) @(negedge clk);
         op_check("rand", 2'($urandom), pick(), pick());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
